// File: rtl/spw_rx_pkg.sv
// ============================================================================
// Module      : spw_rx_pkg
// Description : Shared constants and write-FSM state type for the SpaceWire
//               receive-side N-char writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spw_rx_pkg;

    // Control N-chars carry bit 8 set
    localparam logic [8:0] EOP = 9'h100;
    localparam logic [8:0] EEP = 9'h101;

    // Credit granted by one FCT, and the ceiling of outstanding credit
    localparam int FCT_CREDIT = 8;
    localparam int MAX_CREDIT = 56;

    // FIFO write handshake: strobe, hold, pointer-settle, idle
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2,
        WAIT   = 2'd3
    } wr_state_t;

endpackage

`default_nettype wire

// File: rtl/spw_rx_nchar_writer_if.sv
// ============================================================================
// Module      : spw_rx_nchar_writer_if
// Description : Bundle of decoder, RX FIFO and FCT signals seen by the
//               N-char writer. master = writer, slave = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spw_rx_nchar_writer_if #(
    parameter int DWIDTH = 9,
    parameter int AWIDTH = 6
);
    logic              link_run;
    logic              rx_got_nchar;
    logic [DWIDTH-1:0] rx_nchar;
    logic              fifo_full;
    logic [AWIDTH-1:0] fifo_counter;
    logic              fifo_wr_en;
    logic [DWIDTH-1:0] fifo_data_in;
    logic              fct_req;
    logic              fct_ack;
    logic [AWIDTH-1:0] rx_credit;
    logic              credit_error;
    logic              queue_overrun;
    logic              busy;

    modport master (
        input  link_run, rx_got_nchar, rx_nchar, fifo_full, fifo_counter, fct_ack,
        output fifo_wr_en, fifo_data_in, fct_req, rx_credit, credit_error,
               queue_overrun, busy
    );

    modport slave (
        output link_run, rx_got_nchar, rx_nchar, fifo_full, fifo_counter, fct_ack,
        input  fifo_wr_en, fifo_data_in, fct_req, rx_credit, credit_error,
               queue_overrun, busy
    );
endinterface

`default_nettype wire

// File: rtl/spw_nchar_queue.sv
// ============================================================================
// Module      : spw_nchar_queue
// Description : Small QDEPTH x DWIDTH synchronous FIFO holding N-chars that
//               are waiting for the RX FIFO write handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spw_nchar_queue #(
    parameter  int DWIDTH = 9,
    parameter  int QDEPTH = 4,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = PW + 1
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              push,
    input  wire logic              pop,
    input  wire logic              flush,
    input  wire logic [DWIDTH-1:0] din,
    output logic      [DWIDTH-1:0] head,
    output logic      [CW-1:0]     count,
    output logic                   full,
    output logic                   empty
);

    logic [DWIDTH-1:0] r_mem [QDEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_count == CW'(QDEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    // An empty queue presents zero rather than stale storage
    assign head      = empty ? '0 : r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage array: written on push only, no reset needed
    always_ff @(posedge clock) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; flush discards everything in one cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/spw_rx_nchar_writer.sv
// ============================================================================
// Module      : spw_rx_nchar_writer
// Description : Buffers decoded N-chars, writes them into the RX FIFO with a
//               4-cycle wr_en handshake, and manages receive flow-control
//               credit (FCT requests, credit and overrun error flags).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spw_rx_nchar_writer #(
    parameter int DWIDTH     = 9,
    parameter int AWIDTH     = 6,
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_CREDIT = 56,
    parameter int QDEPTH     = 4
) (
    input wire logic               clock,
    input wire logic               reset,
    spw_rx_nchar_writer_if.master  bus
);

    import spw_rx_pkg::*;

    localparam int QCW = $clog2(QDEPTH) + 1;
    // Wide enough for occupancy + credit + one FCT worth without overflow
    localparam int UW  = AWIDTH + 3;

    wr_state_t         r_state;
    wr_state_t         w_next;
    logic [AWIDTH-1:0] r_credit;
    logic              r_fct_req;
    logic              r_credit_error;
    logic              r_queue_overrun;
    logic [DWIDTH-1:0] r_hold;

    logic [DWIDTH-1:0] w_q_head;
    logic [QCW-1:0]    w_q_count;
    logic              w_q_full;
    logic              w_q_empty;
    logic              w_accept;
    logic              w_has_credit;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_ack;
    logic [UW-1:0]     w_used;
    logic              w_room;
    logic              w_fct_rise;

    assign w_accept     = bus.rx_got_nchar && bus.link_run;
    assign w_has_credit = (r_credit != '0);
    assign w_push       = w_accept && w_has_credit && !w_q_full;
    assign w_pop        = (r_state == HOLD);
    assign w_flush      = !bus.link_run;
    assign w_ack        = bus.fct_ack && r_fct_req;

    // Space the far end could fill: FIFO free slots minus what is already
    // queued or in flight through the write handshake
    assign w_used     = UW'(bus.fifo_counter) + UW'(w_q_count) + UW'(r_state != IDLE);
    assign w_room     = (w_used + UW'(r_credit) + UW'(FCT_CREDIT)) <= UW'(FIFO_DEPTH - 1);
    assign w_fct_rise = (r_credit <= AWIDTH'(MAX_CREDIT - FCT_CREDIT)) && w_room;

    spw_nchar_queue #(
        .DWIDTH (DWIDTH),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clock  (clock),
        .reset  (reset),
        .push   (w_push),
        .pop    (w_pop),
        .flush  (w_flush),
        .din    (bus.rx_nchar),
        .head   (w_q_head),
        .count  (w_q_count),
        .full   (w_q_full),
        .empty  (w_q_empty)
    );

    // Write-FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Write-FSM next state; a started write always runs through WAIT
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_q_empty && !bus.fifo_full && bus.link_run) w_next = STROBE;
            STROBE:  w_next = HOLD;
            HOLD:    w_next = WAIT;
            WAIT:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Capture the head while idle so write data survives the pop and a flush
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                r_hold <= '0;
        else if (r_state == IDLE) r_hold <= w_q_head;
    end

    // Outstanding credit: -1 per accepted char, +8 per acknowledged FCT
    always_ff @(posedge clock or posedge reset) begin
        if (reset)              r_credit <= '0;
        else if (!bus.link_run) r_credit <= '0;
        else                    r_credit <= r_credit - AWIDTH'(w_accept && w_has_credit)
                                            + (w_ack ? AWIDTH'(FCT_CREDIT) : '0);
    end

    // FCT request: raise when there is room for 8 more, hold until acked
    always_ff @(posedge clock or posedge reset) begin
        if (reset)              r_fct_req <= 1'b0;
        else if (!bus.link_run) r_fct_req <= 1'b0;
        else if (r_fct_req)     r_fct_req <= !bus.fct_ack;
        else                    r_fct_req <= w_fct_rise;
    end

    // Sticky error flags, cleared while the link is down
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_credit_error  <= 1'b0;
            r_queue_overrun <= 1'b0;
        end else if (!bus.link_run) begin
            r_credit_error  <= 1'b0;
            r_queue_overrun <= 1'b0;
        end else begin
            if (w_accept && !w_has_credit)             r_credit_error  <= 1'b1;
            if (w_accept && w_has_credit && w_q_full)  r_queue_overrun <= 1'b1;
        end
    end

    a_credit_max: assert property (@(posedge clock) disable iff (reset)
                                   r_credit <= AWIDTH'(MAX_CREDIT));

    assign bus.fifo_wr_en    = (r_state == STROBE);
    assign bus.fifo_data_in  = (r_state == IDLE) ? w_q_head : r_hold;
    assign bus.fct_req       = r_fct_req;
    assign bus.rx_credit     = r_credit;
    assign bus.credit_error  = r_credit_error;
    assign bus.queue_overrun = r_queue_overrun;
    assign bus.busy          = !w_q_empty || (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spw_rx_nchar_writer.sv
// ============================================================================
// Module      : tb_spw_rx_nchar_writer
// Description : Self-checking bench: directed scenarios followed by random
//               traffic, compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spw_rx_nchar_writer;
    import spw_rx_pkg::*;

    localparam int DW    = 9;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int QD    = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    spw_rx_nchar_writer_if #(.DWIDTH(DW), .AWIDTH(AW)) bus_if ();

    spw_rx_nchar_writer #(
        .DWIDTH(DW), .AWIDTH(AW), .FIFO_DEPTH(DEPTH), .MAX_CREDIT(MAX_CREDIT), .QDEPTH(QD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: integer credit, a queue of pending chars, and a
    // countdown of the 4-cycle write (1 = strobe cycle ... 3 = settle cycle)
    int m_credit;
    bit m_fct, m_cerr, m_ovr;
    int m_q[$];
    int m_phase;
    int m_cur;
    int wr_log[$];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_credit = 0; m_fct = 0; m_cerr = 0; m_ovr = 0;
        m_q.delete(); m_phase = 0; m_cur = 0;
    endfunction

    function automatic void model_edge();
        bit run, accept, has, qfull, ack, n_fct;
        int free, n_credit;
        if (reset) begin
            model_reset();
            return;
        end
        run    = bus_if.link_run;
        accept = bus_if.rx_got_nchar && run;
        has    = (m_credit > 0);
        qfull  = (m_q.size() >= QD);
        ack    = bus_if.fct_ack && m_fct;
        free   = (DEPTH - 1) - int'(bus_if.fifo_counter) - m_q.size() - ((m_phase != 0) ? 1 : 0);

        if (!run)       n_fct = 0;
        else if (m_fct) n_fct = !bus_if.fct_ack;
        else            n_fct = (m_credit <= MAX_CREDIT - FCT_CREDIT) && (free >= m_credit + FCT_CREDIT);

        n_credit = run ? (m_credit - ((accept && has) ? 1 : 0) + (ack ? FCT_CREDIT : 0)) : 0;

        if (!run) begin
            m_cerr = 0; m_ovr = 0;
        end else begin
            if (accept && !has)         m_cerr = 1;
            if (accept && has && qfull) m_ovr  = 1;
        end

        case (m_phase)
            0: if (m_q.size() > 0 && !bus_if.fifo_full && run) begin
                   m_cur = m_q[0];
                   m_phase = 1;
               end
            1: m_phase = 2;
            2: begin
                   if (m_q.size() > 0) void'(m_q.pop_front());
                   m_phase = 3;
               end
            default: m_phase = 0;
        endcase

        if (!run) m_q.delete();
        else if (accept && has && !qfull) m_q.push_back(int'(bus_if.rx_nchar));

        m_credit = n_credit;
        m_fct    = n_fct;
    endfunction

    task automatic compare_all();
        check_eq("wr_en",  int'(bus_if.fifo_wr_en),    (m_phase == 1) ? 1 : 0);
        check_eq("credit", int'(bus_if.rx_credit),     m_credit);
        check_eq("fct",    int'(bus_if.fct_req),       int'(m_fct));
        check_eq("cerr",   int'(bus_if.credit_error),  int'(m_cerr));
        check_eq("ovr",    int'(bus_if.queue_overrun), int'(m_ovr));
        check_eq("busy",   int'(bus_if.busy),          (m_q.size() != 0 || m_phase != 0) ? 1 : 0);
        if (m_phase != 0)        check_eq("data_wr",   int'(bus_if.fifo_data_in), m_cur);
        else if (m_q.size() > 0) check_eq("data_head", int'(bus_if.fifo_data_in), m_q[0]);
        if (bus_if.fifo_wr_en) wr_log.push_back(int'(bus_if.fifo_data_in));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare_all();
        bus_if.rx_got_nchar = 1'b0;
        bus_if.fct_ack      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_if.link_run = 1'b0; bus_if.rx_got_nchar = 1'b0; bus_if.rx_nchar = '0;
        bus_if.fifo_full = 1'b0; bus_if.fifo_counter = '0; bus_if.fct_ack = 1'b0;
        step();
        step();
        reset = 1'b0;
        wr_log.delete();
    endtask

    task automatic ack_once();
        for (int k = 0; k < 6 && !m_fct; k++) step();
        check_eq("fct_wait", int'(bus_if.fct_req), 1);
        bus_if.fct_ack = 1'b1;
        step();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Credit build-up to the ceiling
        bus_if.link_run = 1'b1;
        step();
        check_eq("plan_fct_rise", int'(bus_if.fct_req), 1);
        for (int i = 0; i < 7; i++) ack_once();
        repeat (3) step();
        check_eq("plan_credit56", int'(bus_if.rx_credit), 56);
        check_eq("plan_fct_idle", int'(bus_if.fct_req), 0);

        // Single char: latency, data and credit
        do_reset();
        bus_if.link_run = 1'b1;
        ack_once();
        step();
        bus_if.rx_nchar = 9'h041; bus_if.rx_got_nchar = 1'b1;
        step();
        step();
        check_eq("plan_latency", int'(bus_if.fifo_wr_en), 1);
        repeat (8) step();
        check_eq("plan_one_write", wr_log.size(), 1);
        if (wr_log.size() > 0) check_eq("plan_data041", wr_log[0], 'h041);
        check_eq("plan_credit7", int'(bus_if.rx_credit), 7);
        check_eq("plan_not_busy", int'(bus_if.busy), 0);

        // Char with no credit
        do_reset();
        bus_if.link_run = 1'b1;
        bus_if.rx_nchar = 9'h005; bus_if.rx_got_nchar = 1'b1;
        step();
        check_eq("plan_cerr_set", int'(bus_if.credit_error), 1);
        repeat (3) step();
        check_eq("plan_cerr_sticky", int'(bus_if.credit_error), 1);
        check_eq("plan_cerr_nowrite", wr_log.size(), 0);
        bus_if.link_run = 1'b0;
        step();
        check_eq("plan_cerr_clear", int'(bus_if.credit_error), 0);

        // Queue fill while the FIFO is full
        do_reset();
        bus_if.link_run = 1'b1;
        ack_once();
        bus_if.fifo_full = 1'b1;
        wr_log.delete();
        for (int i = 0; i < 5; i++) begin
            bus_if.rx_nchar = DW'(9'h010 + i); bus_if.rx_got_nchar = 1'b1;
            step();
        end
        check_eq("plan_ovr", int'(bus_if.queue_overrun), 1);
        check_eq("plan_credit3", int'(bus_if.rx_credit), 3);
        bus_if.fifo_full = 1'b0;
        repeat (20) step();
        check_eq("plan_four_writes", wr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++) check_eq("plan_order", wr_log[i], 'h010 + i);

        // Simultaneous FCT ack and char acceptance
        do_reset();
        bus_if.link_run = 1'b1;
        repeat (5) ack_once();
        for (int k = 0; k < 6 && !m_fct; k++) step();
        check_eq("plan_credit40", int'(bus_if.rx_credit), 40);
        bus_if.rx_nchar = 9'h022; bus_if.rx_got_nchar = 1'b1; bus_if.fct_ack = 1'b1;
        step();
        check_eq("plan_credit47", int'(bus_if.rx_credit), 47);

        // Link drop in the middle of the strobe
        wr_log.delete();
        for (int k = 0; k < 6 && m_phase != 1; k++) step();
        check_eq("plan_strobe", int'(bus_if.fifo_wr_en), 1);
        bus_if.link_run = 1'b0;
        repeat (6) step();
        check_eq("plan_drop_one_write", wr_log.size(), 1);
        check_eq("plan_drop_idle", int'(bus_if.busy), 0);
        check_eq("plan_drop_credit", int'(bus_if.rx_credit), 0);

        // Random traffic
        do_reset();
        bus_if.link_run = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (bus_if.link_run) begin
                if ($urandom_range(0, 249) == 0) bus_if.link_run = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                bus_if.link_run = 1'b1;
            end
            bus_if.rx_got_nchar = ($urandom_range(0, 99) < 35);
            case ($urandom_range(0, 9))
                0:       bus_if.rx_nchar = EOP;
                1:       bus_if.rx_nchar = EEP;
                default: bus_if.rx_nchar = DW'($urandom_range(0, 255));
            endcase
            bus_if.fct_ack = m_fct ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) bus_if.fifo_full = !bus_if.fifo_full;
            if ($urandom_range(0, 15) == 0) bus_if.fifo_counter = AW'($urandom_range(0, 63));
            reset = ($urandom_range(0, 999) == 0);
            step();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spw_rx_nchar_writer.md
Name: spw_rx_nchar_writer

Overview:
- Sits between the SpaceWire receiver's character decoder and the 64-entry RX FIFO.
- Accepts decoded N-chars (data, EOP, EEP) and buffers them in a small pending queue.
- Writes them into the FIFO using its multi-cycle wr_en protocol.
- Owns the receive-side flow-control credit: requests FCTs from the transmitter, counts credit, and flags credit errors and queue overruns.

Parameters:
DWIDTH, 9, N-char width; bit 8 = control flag (9'h100 EOP, 9'h101 EEP)
AWIDTH, 6, FIFO address / occupancy width
FIFO_DEPTH, 64, FIFO entries; usable capacity FIFO_DEPTH-1
MAX_CREDIT, 56, maximum outstanding credit (7 FCTs)
QDEPTH, 4, pending-queue entries (power of two)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
link_run  in  1  link FSM in Run; low = flush/disable
rx_got_nchar  in  1  one-cycle strobe: rx_nchar valid
rx_nchar  in  DWIDTH  decoded N-char
fifo_full  in  1  FIFO full flag
fifo_counter  in  AWIDTH  FIFO occupancy
fifo_wr_en  out  1  FIFO write enable
fifo_data_in  out  DWIDTH  FIFO write data
fct_req  out  1  request TX to send one FCT
fct_ack  in  1  one-cycle strobe: FCT transmitted
rx_credit  out  AWIDTH  outstanding credit (N-chars the far end may still send)
credit_error  out  1  sticky: N-char arrived with rx_credit==0
queue_overrun  out  1  sticky: N-char arrived with queue full
busy  out  1  queue non-empty or write FSM not IDLE

Behaviour:
- Reset: all outputs 0, rx_credit=0, queue empty, FSM IDLE.
- fifo_data_in always equals the queue head; it is stable from IDLE through WAIT.
- Write FSM:
  - IDLE -> STROBE when queue non-empty && !fifo_full.
  - STROBE: fifo_wr_en=1 for exactly one cycle -> HOLD.
  - HOLD: fifo_wr_en=0; pop the queue at the end of the cycle -> WAIT.
  - WAIT: one cycle, lets the FIFO advance its pointer -> IDLE.
  - Throughput: 1 N-char per 4 clocks. Latency from rx_got_nchar to fifo_wr_en is 2 clocks when the queue was empty and the FSM was IDLE.
- Accepting an N-char (rx_got_nchar && link_run):
  - rx_credit==0: set credit_error, drop the char, credit unchanged.
  - Else if queue full (including simultaneous pop): set queue_overrun, drop the char. Credit is still decremented.
  - Else push the char and decrement rx_credit by 1.
- FCT request:
  - free = (FIFO_DEPTH-1) - fifo_counter - queue_count - (FSM!=IDLE ? 1 : 0).
  - fct_req rises when link_run && !fct_req && rx_credit <= MAX_CREDIT-8 && free >= rx_credit+8.
  - fct_req holds high until fct_ack; it drops the cycle after fct_ack.
  - fct_ack while fct_req: rx_credit += 8. fct_ack without fct_req is ignored.
- fct_ack and N-char acceptance in the same cycle: net rx_credit +7.
- rx_credit never exceeds MAX_CREDIT and never wraps below 0 (guaranteed by the rules above). The implementation asserts on violation.
- link_run low (async to the data path, sampled):
  - Queue flushed, rx_credit=0, fct_req=0, credit_error and queue_overrun cleared, rx_got_nchar ignored.
  - A write in STROBE/HOLD/WAIT completes through WAIT so the FIFO handshake is never broken mid-cycle. The popped entry is still written.
- fifo_full asserted: the FSM waits in IDLE, and the queue absorbs up to QDEPTH chars.
- reset mid-write: immediate return to reset values. The FIFO is reset by the same signal.

Decomposition:
- Shared package spw_rx_pkg:
  - N-char constants EOP=9'h100, EEP=9'h101.
  - Write-FSM state encoding (IDLE, STROBE, HOLD, WAIT as 2-bit).
  - MAX_CREDIT, FCT_CREDIT=8.
- One sub-module: spw_nchar_queue, a QDEPTH x DWIDTH synchronous FIFO.
  - Inputs: push, pop, flush.
  - Outputs: head, count, full, empty.
  - Simultaneous push/pop allowed when full.

Test Plan:
- Reset, link_run=1, fifo_counter=0 -> fct_req=1 within 2 clocks. Ack 7 times -> rx_credit=56, fct_req stays 0 (56 > 48).
- rx_credit=8, send 1 N-char 9'h041 -> fifo_wr_en pulses once 2 clocks later with fifo_data_in=9'h041, rx_credit=7, busy clears after WAIT.
- rx_credit=0, rx_got_nchar -> credit_error=1 and stays 1, no fifo_wr_en. Drop link_run -> credit_error=0.
- fifo_full=1, credit 8, send 5 chars back-to-back -> first 4 queued, 5th sets queue_overrun, rx_credit=3. Release fifo_full -> 4 writes spaced 4 clocks apart, in order.
- fct_ack and rx_got_nchar in the same cycle with rx_credit=40 -> rx_credit=47.
- Deassert link_run during STROBE -> fifo_wr_en completes its single pulse, FSM reaches IDLE after WAIT, queue empty, rx_credit=0.
